// File: rtl/line_fetch_scaler.sv
// line_fetch_scaler: double-buffered source-line fetcher with integer pixel/line
// replication for a scaled display.
//
// A three-state fetch engine (IDLE/REQ/WAIT) pulls one source line, one 32-bit
// word (four pixels) at a time, into one of two line banks. The display side
// replays each source pixel SCALE times horizontally. Each source line is shown
// for SCALE output lines while the next line is fetched into the other bank.
//
// Parameters
//   H_PIXELS  source pixels per line (multiple of 4)
//   V_LINES   source lines per frame
//   SCALE     horizontal/vertical replication factor, 1..4
//   ADDR_W    memory word-address width
//   BORDER    colour shown outside valid pixels
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   frame_start            frame start pulse (restarts at line 0)
//   line_start             output line start pulse
//   base_addr              word address of source line 0
//   mem_req/mem_addr       read request and word address
//   mem_ack                request accepted this cycle
//   mem_rvalid/mem_rdata   read data return (byte 0 = lowest x)
//   pix_req                output pixel strobe
//   pix_out/pix_valid      pixel colour, valid the cycle after pix_req
//   busy                   fetch engine not idle
//   underrun               sticky "displayed a bank that was not ready"
//
// Build option
//   LINE_FETCH_UNDERRUN_EN  when defined, strobes on a not-ready bank show
//                           BORDER and set underrun; otherwise underrun is 0
//                           and stale bank data is shown.

module line_fetch_scaler #(
  parameter int unsigned H_PIXELS = 256,
  parameter int unsigned V_LINES  = 192,
  parameter int unsigned SCALE    = 3,
  parameter int unsigned ADDR_W   = 22,
  parameter logic [7:0]  BORDER   = 8'h07
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              pix_req,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  output logic              busy,
  output logic              underrun
);

  localparam int unsigned WORDS  = H_PIXELS / 4;
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int unsigned PX_W   = $clog2(H_PIXELS + 1);
  localparam int unsigned HX_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);
  localparam logic [HX_W-1:0]   LAST_HX   = HX_W'(SCALE - 1);
  localparam logic [PX_W-1:0]   PX_END    = PX_W'(H_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Fetch engine state
  state_e              state_q, state_d;
  logic                drop_q, drop_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                tgt_q, tgt_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [1:0]          ready_q, ready_d;

  // Vertical sequencing
  logic [LINE_W-1:0]   src_y_q, src_y_d;
  logic [HX_W-1:0]     yc_q, yc_d;
  logic                disp_bank_q, disp_bank_d;
  logic                first_q, first_d;

  // Horizontal counters; px saturates at H_PIXELS to mean "past the line end"
  logic [PX_W-1:0]     px_q, px_d;
  logic [HX_W-1:0]     hx_q, hx_d;

  // Registered outputs
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic [7:0]          pix_out_q, pix_out_d;
  logic                pix_valid_q, pix_valid_d;
  logic                underrun_q, underrun_d;

  // Launch request from the sequencer
  logic                launch_c;
  logic [LINE_W-1:0]   launch_line_c;
  logic                launch_bank_c;

  // Bank write/read
  logic                wr_en_c;
  logic [31:0]         rd_word_c;
  logic [7:0]          rd_byte_c;

  // Line banks, one 32-bit word per four pixels; contents are not reset
  logic [31:0]         bank_mem [2][WORDS];

  // Vertical sequencer: decides when and which line to launch
  always_comb begin
    src_y_d       = src_y_q;
    yc_d          = yc_q;
    disp_bank_d   = disp_bank_q;
    first_d       = first_q;
    launch_c      = 1'b0;
    launch_line_c = '0;
    launch_bank_c = 1'b0;

    if (frame_start) begin
      src_y_d     = '0;
      yc_d        = '0;
      disp_bank_d = 1'b0;
      first_d     = 1'b1;
      launch_c    = 1'b1;
    end else if (line_start) begin
      if (first_q) begin
        // first output line shows line 0; prefetch line 1 behind it
        first_d = 1'b0;
        if (V_LINES > 1) begin
          launch_c      = 1'b1;
          launch_line_c = LINE_W'(1);
          launch_bank_c = 1'b1;
        end
      end else if (yc_q == LAST_HX) begin
        yc_d = '0;
        // once the last source line is reached, keep showing it
        if (src_y_q != LAST_LINE) begin
          src_y_d     = src_y_q + LINE_W'(1);
          disp_bank_d = ~disp_bank_q;
          if (src_y_d != LAST_LINE) begin
            launch_c      = 1'b1;
            launch_line_c = src_y_q + LINE_W'(2);
            launch_bank_c = disp_bank_q;
          end
        end
      end else begin
        yc_d = yc_q + HX_W'(1);
      end
    end
  end

  // Fetch FSM next state, bank write enable and memory request
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    line_d     = line_q;
    tgt_d      = tgt_q;
    widx_d     = widx_q;
    ready_d    = ready_q;
    wr_en_c    = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    busy_d     = 1'b0;

    if (launch_c) begin
      line_d                 = launch_line_c;
      tgt_d                  = launch_bank_c;
      widx_d                 = '0;
      ready_d[launch_bank_c] = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end
        ST_REQ: begin
          // a request accepted this same cycle still has data in flight
          state_d = mem_ack ? ST_WAIT : ST_REQ;
          drop_d  = mem_ack;
        end
        ST_WAIT: begin
          // data returning this cycle belongs to the abandoned fetch
          state_d = mem_rvalid ? ST_REQ : ST_WAIT;
          drop_d  = ~mem_rvalid;
        end
        default: begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_REQ: begin
          if (mem_ack) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              wr_en_c = 1'b1;
              if (widx_q == LAST_WORD) begin
                state_d        = ST_IDLE;
                ready_d[tgt_q] = 1'b1;
              end else begin
                widx_d  = widx_q + WIDX_W'(1);
                state_d = ST_REQ;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_REQ) begin
      mem_req_d  = 1'b1;
      mem_addr_d = base_addr + ADDR_W'(line_d) * ADDR_W'(WORDS) + ADDR_W'(widx_d);
    end
  end

  // Display-bank byte lookup at the current horizontal position
  always_comb begin
    rd_word_c = bank_mem[disp_bank_q][px_q[WIDX_W+1:2]];
    unique case (px_q[1:0])
      2'd0:    rd_byte_c = rd_word_c[7:0];
      2'd1:    rd_byte_c = rd_word_c[15:8];
      2'd2:    rd_byte_c = rd_word_c[23:16];
      default: rd_byte_c = rd_word_c[31:24];
    endcase
  end

  // Pixel output and horizontal replication
  always_comb begin
    px_d        = px_q;
    hx_d        = hx_q;
    pix_out_d   = pix_out_q;
    pix_valid_d = 1'b0;
`ifdef LINE_FETCH_UNDERRUN_EN
    underrun_d  = underrun_q;
`else
    underrun_d  = 1'b0;
`endif

    if (pix_req) begin
      pix_valid_d = 1'b1;
      pix_out_d   = (px_q == PX_END) ? BORDER : rd_byte_c;
`ifdef LINE_FETCH_UNDERRUN_EN
      if (!ready_q[disp_bank_q]) begin
        pix_out_d  = BORDER;
        underrun_d = 1'b1;
      end
`endif
      if (hx_q == LAST_HX) begin
        hx_d = '0;
        if (px_q != PX_END) px_d = px_q + PX_W'(1);
      end else begin
        hx_d = hx_q + HX_W'(1);
      end
    end

    if (frame_start || line_start) begin
      px_d = '0;
      hx_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      line_q      <= '0;
      tgt_q       <= 1'b0;
      widx_q      <= '0;
      ready_q     <= '0;
      src_y_q     <= '0;
      yc_q        <= '0;
      disp_bank_q <= 1'b0;
      first_q     <= 1'b1;
      px_q        <= '0;
      hx_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      line_q      <= line_d;
      tgt_q       <= tgt_d;
      widx_q      <= widx_d;
      ready_q     <= ready_d;
      src_y_q     <= src_y_d;
      yc_q        <= yc_d;
      disp_bank_q <= disp_bank_d;
      first_q     <= first_d;
      px_q        <= px_d;
      hx_q        <= hx_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  // Bank write port; a return arriving while reset is held is dropped
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) bank_mem[tgt_q][widx_q] <= mem_rdata;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_line_fetch_scaler.sv
// Testbench for line_fetch_scaler: directed frame/line sequences with random
// memory latencies, random source pixels and random strobe gaps, checked
// against a line-level reference model (which source line is shown, which
// bank holds which words, which banks are ready).
module tb_line_fetch_scaler;

  localparam int          H     = 256;
  localparam int          VL    = 192;
  localparam int          SC    = 3;
  localparam int          WORDS = H / 4;
  localparam logic [7:0]  BRD   = 8'h07;
  localparam int          BASE  = 32'h1000;
`ifdef LINE_FETCH_UNDERRUN_EN
  localparam bit UNDER_EN = 1'b1;
`else
  localparam bit UNDER_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [21:0] base_addr;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        pix_req;
  logic [7:0]  pix_out;
  logic        pix_valid;
  logic        busy;
  logic        underrun;

  line_fetch_scaler dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .line_start (line_start),
    .base_addr  (base_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .pix_req    (pix_req),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source image (first four lines) and reference model state
  logic [7:0] src      [4][H];
  logic [7:0] ref_bank [2][H];
  bit         ref_ready [2];
  int         cur_line;   // line being fetched, -1 when idle
  int         cur_word;
  int         m_ls;       // line_starts since the first one of the frame
  int         m_str;      // strobes since the current output line began
  bit         m_first;
  bit         m_under;
  logic [7:0] last_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int l, input int w);
    return {src[l][4*w+3], src[l][4*w+2], src[l][4*w+1], src[l][4*w]};
  endfunction

  function automatic int disp_bank();
    int s;
    s = m_ls / SC;
    if (s > VL - 1) s = VL - 1;
    return s % 2;
  endfunction

  task automatic model_reset();
    ref_ready[0] = 1'b0;
    ref_ready[1] = 1'b0;
    cur_line = -1;
    cur_word = 0;
    m_ls     = 0;
    m_str    = 0;
    m_first  = 1'b1;
    m_under  = 1'b0;
    last_pix = 8'h00;
  endtask

  task automatic launch(input int l);
    ref_ready[l % 2] = 1'b0;
    cur_line = l;
    cur_word = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"},   mem_req,   0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_pix_out"},   pix_out,   0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_underrun"},  underrun,  0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_first = 1'b1;
    m_ls    = 0;
    m_str   = 0;
    launch(0);
    chk("busy_after_frame", busy, 1);
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    m_str = 0;
    if (m_first) begin
      m_first = 1'b0;
      launch(1);
    end else begin
      m_ls++;
      if ((m_ls % SC) == 0 && (m_ls / SC) < VL - 1) launch(m_ls / SC + 1);
    end
    chk("busy_after_line", busy, (cur_line >= 0));
  endtask

  // Wait (bounded) for a request and check its address
  task automatic wait_req(output bit ok);
    int t = 0;
    while (mem_req !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    ok = (mem_req === 1'b1);
    if (!ok) chk("req_timeout", mem_req, 1);
    else chk("mem_addr", mem_addr, 32'(BASE + cur_line * WORDS + cur_word));
  endtask

  task automatic ack_only();
    bit ok;
    wait_req(ok);
    if (ok) begin
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("req_low_in_wait", mem_req, 0);
    end
  endtask

  task automatic serve_words(input int n);
    bit ok;
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      wait_req(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("req_hold", mem_req, 1);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("req_low_in_wait", mem_req, 0);
      repeat ($urandom_range(0, 2)) step();
      d = word_of(cur_line, cur_word);
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      step();
      mem_rvalid = 1'b0;
      for (int b = 0; b < 4; b++) ref_bank[cur_line % 2][4*cur_word+b] = d[8*b +: 8];
      cur_word++;
      if (cur_word == WORDS) begin
        ref_ready[cur_line % 2] = 1'b1;
        cur_line = -1;
        chk("busy_done", busy, 0);
      end
    end
  endtask

  task automatic row_pixels(input int n);
    int d;
    int p;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("idle_valid", pix_valid, 0);
        chk("idle_hold", pix_out, last_pix);
      end
      d = disp_bank();
      p = m_str / SC;
      e = (p >= H) ? BRD : ref_bank[d][p];
      if (UNDER_EN && !ref_ready[d]) begin
        e = BRD;
        m_under = 1'b1;
      end
      m_str++;
      pix_req = 1'b1;
      step();
      pix_req = 1'b0;
      chk("pix_valid", pix_valid, 1);
      chk("pix_out", pix_out, e);
      chk("underrun", underrun, m_under);
      last_pix = e;
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++)
      for (int x = 0; x < H; x++)
        src[l][x] = (l == 0) ? 8'(x) : 8'($urandom);
    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; base_addr = 22'h1000;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pix_req = 1'b0;
    model_reset();
    repeat (3) step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk_reset("post_rst");

    // Frame: line 0 into bank 0, full replicated line plus one past the end
    pulse_frame();
    serve_words(WORDS);
    pulse_line();
    row_pixels(H * SC + 1);
    serve_words(WORDS);
    pulse_line();
    row_pixels($urandom_range(30, 60));
    pulse_line();
    row_pixels($urandom_range(30, 60));
    pulse_line();
    row_pixels(60);
    serve_words(WORDS);
    pulse_line();
    row_pixels($urandom_range(30, 60));
    pulse_line();
    row_pixels($urandom_range(30, 60));
    pulse_line();

    // Abandon line 3 while a read is outstanding; its return must be dropped
    serve_words(5);
    ack_only();
    pulse_frame();
    chk("drop_wait_req", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = ~word_of(3, 5);
    step();
    mem_rvalid = 1'b0;
    chk("refetch_req", mem_req, 1);
    serve_words(WORDS);

    // Abandon line 1 while still requesting; bank 1 keeps line 3 head / line 1 tail
    pulse_line();
    pulse_line();
    pulse_line();
    pulse_line();
    row_pixels(100);
    serve_words(WORDS);

    // Reset while waiting for data, then a stray return
    pulse_frame();
    serve_words(3);
    ack_only();
    rst = 1'b1;
    step();
    chk_reset("rst_wait");
    model_reset();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = ~word_of(0, 3);
    step();
    mem_rvalid = 1'b0;
    chk_reset("stray_rvalid");
    row_pixels(20 * SC);

`ifdef LINE_FETCH_UNDERRUN_EN
    pulse_frame();
    row_pixels(1);
    pulse_frame();
    chk("underrun_sticky", underrun, 1);
    rst = 1'b1;
    step();
    chk("underrun_rst", underrun, 0);
    model_reset();
    rst = 1'b0;
    step();
`else
    chk("underrun_tied", underrun, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
